// File: rtl/uart_rx_oversample.sv
// UART receiver with 16x oversampling. A 2-of-3 majority filter is applied to every line decision.
// Status flags latch one clk after the stop-bit sample, so a read in that same clk still sees the old character.
module uart_rx_oversample #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       baud_clock,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   input  logic       rx,
   input  logic       read_rx_byte,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       parity_err,
   output logic       framing_err,
   output logic       overflow,
   output logic       rx_idle
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                 state_q;
   logic [3:0]             cnt_q;
   logic [2:0]             idx_q;
   logic [7:0]             shift_q;
   logic                   bit8_q;
   logic                   par_en_q;
   logic                   odd_q;
   logic                   perr_calc_q;
   logic                   stop_bit_q;
   logic                   done_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [2:0]             sample_q;
   logic                   rx_filt;
   logic [2:0]             last_idx;

   logic [7:0]             rx_data_q,     rx_data_d;
   logic                   rx_ready_q,    rx_ready_d;
   logic                   parity_err_q,  parity_err_d;
   logic                   framing_err_q, framing_err_d;
   logic                   overflow_q,    overflow_d;

   assign rx_filt  = (sample_q[0] & sample_q[1]) | (sample_q[0] & sample_q[2]) |
                     (sample_q[1] & sample_q[2]);
   assign last_idx = bit8_q ? 3'd7 : 3'd6;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '1;
         sample_q <= 3'b111;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         if (baud_clock) begin
            sample_q <= {sample_q[1:0], sync_q[SYNC_STAGES-1]};
         end
      end
   end

   // Frame format is captured once the start bit is confirmed, so mid-frame config changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         idx_q       <= 3'd0;
         shift_q     <= 8'd0;
         bit8_q      <= 1'b0;
         par_en_q    <= 1'b0;
         odd_q       <= 1'b0;
         perr_calc_q <= 1'b0;
         stop_bit_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (baud_clock) begin
            case (state_q)
               IDLE: begin
                  if (!rx_filt) begin
                     state_q <= START;
                     cnt_q   <= 4'd0;
                  end
               end
               START: begin
                  if (cnt_q == 4'd7) begin
                     if (!rx_filt) begin
                        state_q     <= DATA;
                        cnt_q       <= 4'd0;
                        idx_q       <= 3'd0;
                        shift_q     <= 8'd0;
                        bit8_q      <= bit8;
                        par_en_q    <= parity_en;
                        odd_q       <= odd_n_even;
                        perr_calc_q <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                     end
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               DATA: begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     shift_q[idx_q] <= rx_filt;
                     idx_q          <= idx_q + 3'd1;
                     if (idx_q == last_idx) begin
                        state_q <= par_en_q ? PARITY : STOP;
                     end
                  end
               end
               PARITY: begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     perr_calc_q <= (^shift_q) ^ rx_filt ^ odd_q;
                     state_q     <= STOP;
                  end
               end
               STOP: begin
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     stop_bit_q <= rx_filt;
                     done_q     <= 1'b1;
                     state_q    <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end
            endcase
         end
      end
   end

   always_comb begin
      rx_data_d     = rx_data_q;
      rx_ready_d    = rx_ready_q;
      parity_err_d  = parity_err_q;
      framing_err_d = framing_err_q;
      overflow_d    = overflow_q;
      if (done_q) begin
         framing_err_d = !stop_bit_q;
         if (!rx_ready_q || read_rx_byte) begin
            rx_data_d    = shift_q;
            rx_ready_d   = 1'b1;
            parity_err_d = perr_calc_q;
            overflow_d   = 1'b0;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (read_rx_byte && rx_ready_q) begin
         rx_ready_d   = 1'b0;
         parity_err_d = 1'b0;
         overflow_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_q     <= 8'd0;
         rx_ready_q    <= 1'b0;
         parity_err_q  <= 1'b0;
         framing_err_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         rx_data_q     <= rx_data_d;
         rx_ready_q    <= rx_ready_d;
         parity_err_q  <= parity_err_d;
         framing_err_q <= framing_err_d;
         overflow_q    <= overflow_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_ready    = rx_ready_q;
   assign parity_err  = parity_err_q;
   assign framing_err = framing_err_q;
   assign overflow    = overflow_q;
   assign rx_idle     = (state_q == IDLE);

endmodule
